// File: rtl/modmul_interleaved_if.sv
// Start/busy/done handshake bundle for the interleaved modular multiplier.
// The master drives the request and operands; the slave returns status and the product.
interface modmul_interleaved_if #(
    parameter int WIDTH = 256
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] m;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] product;

    modport master (output start, a, b, m, input busy, done, err, product);
    modport slave  (input start, a, b, m, output busy, done, err, product);
endinterface

// File: rtl/modmul_interleaved.sv
// MSB-first interleaved modular multiplier: product = (a*b) mod m, one multiplier bit per clock.
// Operands are checked on accept; invalid operands skip RUN and report err with product 0.
module modmul_interleaved #(
    parameter  int WIDTH = 256,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                Reset,
    modmul_interleaved_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, m_r, acc;
    logic [WIDTH-1:0] product_r;
    logic             err_r;
    logic [CNT_W-1:0] idx;
    logic             operands_ok;

    // Reductions run one bit wider so 2*acc and t1+b never lose their carry.
    logic [WIDTH:0] m_ext, dbl, t1, t2, t2_red;
    logic [WIDTH-1:0] acc_nxt;

    assign operands_ok = (bus.m >= WIDTH'(2)) && (bus.a < bus.m) && (bus.b < bus.m);

    always_comb begin
        m_ext   = {1'b0, m_r};
        dbl     = {acc, 1'b0};
        t1      = (dbl >= m_ext) ? dbl - m_ext : dbl;
        t2      = t1 + (a_r[idx] ? {1'b0, b_r} : '0);
        t2_red  = (t2 >= m_ext) ? t2 - m_ext : t2;
        acc_nxt = t2_red[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = operands_ok ? RUN : DONE;
            RUN:     if (idx == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state != IDLE);
        bus.done    = (state == DONE);
        bus.err     = err_r;
        bus.product = product_r;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            a_r       <= '0;
            b_r       <= '0;
            m_r       <= '0;
            acc       <= '0;
            idx       <= '0;
            product_r <= '0;
            err_r     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r       <= bus.a;
                        b_r       <= bus.b;
                        m_r       <= bus.m;
                        acc       <= '0;
                        idx       <= CNT_W'(WIDTH - 1);
                        product_r <= '0;
                        err_r     <= !operands_ok;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    idx <= idx - CNT_W'(1);
                    if (idx == '0) begin
                        product_r <= acc_nxt;
                        err_r     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
